// File: rtl/fifo_push_wr.sv
// AXI write-channel push stage: accepts one AW then its W beats, forwarding each handshake
// straight into the AW/W FIFOs with zero latency. Optional WLAST checker via WLAST_CHECK_EN.
module fifo_push_wr #(
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 64,
  parameter int LEN_WIDTH   = 8,
  parameter int SIZE_WIDTH  = 3,
  parameter int BURST_WIDTH = 2,
  parameter int USER_WIDTH  = 3,
  parameter int DATA_WIDTH  = 1024,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                   CLK,
  input  logic                   ARESTn,
  input  logic [ID_WIDTH-1:0]    AWID,
  input  logic [ADDR_WIDTH-1:0]  AWADDR,
  input  logic [LEN_WIDTH-1:0]   AWLEN,
  input  logic [SIZE_WIDTH-1:0]  AWSIZE,
  input  logic [BURST_WIDTH-1:0] AWBURST,
  input  logic [USER_WIDTH-1:0]  AWUSER,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [DATA_WIDTH-1:0]  WDATA,
  input  logic [STRB_WIDTH-1:0]  WSTRB,
  input  logic                   WLAST,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic                   aw_fifo_wr_en,
  output logic [ID_WIDTH+ADDR_WIDTH+LEN_WIDTH+SIZE_WIDTH+BURST_WIDTH+USER_WIDTH-1:0]
                                 aw_fifo_wr_data,
  input  logic                   aw_fifo_full,
  output logic                   w_fifo_wr_en,
  output logic [DATA_WIDTH+STRB_WIDTH-1:0] w_fifo_wr_data,
  input  logic                   w_fifo_full,
  output logic                   burst_active,
  output logic                   wlast_err
);

  typedef enum logic [0:0] {StIdle, StData} state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge ARESTn) begin
    if (!ARESTn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gated by reset because IDLE is also the reset state.
        AWREADY = ARESTn && !aw_fifo_full && !w_fifo_full;
        if (AWVALID && AWREADY) begin
          cnt_d   = AWLEN;
          state_d = StData;
        end
      end
      StData: begin
        WREADY = !w_fifo_full;
        if (WVALID && WREADY) begin
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign aw_fifo_wr_en   = AWVALID && AWREADY;
  assign aw_fifo_wr_data = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWUSER};
  assign w_fifo_wr_en    = WVALID && WREADY;
  assign w_fifo_wr_data  = {WDATA, WSTRB};
  assign burst_active    = (state_q == StData);

`ifdef WLAST_CHECK_EN
  assign wlast_err = w_fifo_wr_en && (WLAST != (cnt_q == '0));
`else
  logic unused_wlast;
  assign unused_wlast = WLAST;
  assign wlast_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_push_wr.sv
// Scoreboard bench for fifo_push_wr: stimulus queues expected FIFO pushes, a negedge monitor
// pops and compares them; directed checks cover ready/burst_active timing and reset.
module tb_fifo_push_wr;
  localparam int IdW = 4, AddrW = 32, LenW = 8, SizeW = 3, BurstW = 2, UserW = 3;
  localparam int DataW = 32, StrbW = 4;
  localparam int AwW = IdW + AddrW + LenW + SizeW + BurstW + UserW;
  localparam int WW  = DataW + StrbW;

  logic CLK = 1'b0, ARESTn = 1'b0;
  logic [IdW-1:0] AWID = '0;
  logic [AddrW-1:0] AWADDR = '0;
  logic [LenW-1:0] AWLEN = '0;
  logic [SizeW-1:0] AWSIZE = '0;
  logic [BurstW-1:0] AWBURST = '0;
  logic [UserW-1:0] AWUSER = '0;
  logic AWVALID = 1'b0, AWREADY;
  logic [DataW-1:0] WDATA = '0;
  logic [StrbW-1:0] WSTRB = '0;
  logic WLAST = 1'b0, WVALID = 1'b0, WREADY;
  logic aw_fifo_wr_en, aw_fifo_full = 1'b0;
  logic [AwW-1:0] aw_fifo_wr_data;
  logic w_fifo_wr_en, w_fifo_full = 1'b0;
  logic [WW-1:0] w_fifo_wr_data;
  logic burst_active, wlast_err;

  fifo_push_wr #(
    .ID_WIDTH(IdW), .ADDR_WIDTH(AddrW), .LEN_WIDTH(LenW), .SIZE_WIDTH(SizeW),
    .BURST_WIDTH(BurstW), .USER_WIDTH(UserW), .DATA_WIDTH(DataW), .STRB_WIDTH(StrbW)
  ) dut (
    .CLK(CLK), .ARESTn(ARESTn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWUSER(AWUSER), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .aw_fifo_wr_en(aw_fifo_wr_en), .aw_fifo_wr_data(aw_fifo_wr_data),
    .aw_fifo_full(aw_fifo_full),
    .w_fifo_wr_en(w_fifo_wr_en), .w_fifo_wr_data(w_fifo_wr_data), .w_fifo_full(w_fifo_full),
    .burst_active(burst_active), .wlast_err(wlast_err)
  );

  always #5 CLK = ~CLK;

  int n_total = 0, n_pass = 0;
  int aw_pushes = 0, w_pushes = 0;
  logic [AwW-1:0] aw_q[$];
  logic [WW-1:0]  w_q[$];
  logic           err_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic exp_err(input logic last, input logic is_final);
`ifdef WLAST_CHECK_EN
    return last != is_final;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every FIFO push must match the oldest expected entry.
  always @(negedge CLK) begin
    if (aw_fifo_wr_en) begin
      aw_pushes++;
      if (aw_q.size() == 0) check("aw_unexpected_push", 64'(aw_fifo_wr_data), 64'h0);
      else check("aw_payload", 64'(aw_fifo_wr_data), 64'(aw_q.pop_front()));
    end
    if (w_fifo_wr_en) begin
      w_pushes++;
      if (w_q.size() == 0) check("w_unexpected_push", 64'(w_fifo_wr_data), 64'h0);
      else begin
        check("w_payload", 64'(w_fifo_wr_data), 64'(w_q.pop_front()));
        check("wlast_err", 64'(wlast_err), 64'(err_q.pop_front()));
      end
    end else if (wlast_err) begin
      check("wlast_err_no_push", 64'(wlast_err), 64'h0);
    end
  end

  function automatic logic [AwW-1:0] aw_word(input logic [IdW-1:0] id,
                                             input logic [AddrW-1:0] addr,
                                             input logic [LenW-1:0] len);
    return {id, addr, len, 3'd2, 2'b01, 3'd5};
  endfunction

  task automatic drive_aw(input logic [IdW-1:0] id, input logic [AddrW-1:0] addr,
                          input logic [LenW-1:0] len);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = 2'b01; AWUSER = 3'd5;
    AWVALID = 1'b1;
  endtask

  task automatic send_aw(input logic [IdW-1:0] id, input logic [AddrW-1:0] addr,
                         input logic [LenW-1:0] len);
    int n = 0;
    aw_q.push_back(aw_word(id, addr, len));
    drive_aw(id, addr, len);
    @(negedge CLK);
    while (!AWREADY && n < 50) begin @(negedge CLK); n++; end
    if (!AWREADY) check("aw_timeout", 64'(AWREADY), 64'h1);
    @(posedge CLK); #1;
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [DataW-1:0] d, input logic [StrbW-1:0] s,
                        input logic last, input logic is_final);
    int n = 0;
    w_q.push_back({d, s});
    err_q.push_back(exp_err(last, is_final));
    WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
    @(negedge CLK);
    while (!WREADY && n < 50) begin @(negedge CLK); n++; end
    if (!WREADY) check("w_timeout", 64'(WREADY), 64'h1);
    @(posedge CLK); #1;
    WVALID = 1'b0;
  endtask

  initial begin
    #12;
    check("reset_outputs", 64'({AWREADY, WREADY, aw_fifo_wr_en, w_fifo_wr_en,
                                burst_active, wlast_err}), 64'h0);
    @(posedge CLK); #1;
    ARESTn = 1'b1;
    @(negedge CLK);
    check("idle_awready", 64'(AWREADY), 64'h1);
    check("idle_wready", 64'(WREADY), 64'h0);
    @(posedge CLK); #1;

    // AWLEN=0, ID=3 with AW and W offered together.
    WDATA = 32'hA5A5_0001; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    @(negedge CLK);
    check("w_blocked_before_aw", 64'({WREADY, w_fifo_wr_en}), 64'h0);
    @(posedge CLK); #1;
    aw_q.push_back(aw_word(4'd3, 32'h1000, 8'd0));
    drive_aw(4'd3, 32'h1000, 8'd0);
    w_q.push_back({32'hA5A5_0001, 4'hF});
    err_q.push_back(exp_err(1'b1, 1'b1));
    @(negedge CLK);
    check("aw_first_same_cycle", 64'({AWREADY, WREADY, w_fifo_wr_en}), 64'b100);
    check("aw_id_field", 64'(aw_fifo_wr_data[AwW-1 -: IdW]), 64'd3);
    @(posedge CLK); #1;
    AWVALID = 1'b0;
    @(negedge CLK);
    check("burst_active_beat", 64'({burst_active, WREADY}), 64'b11);
    @(posedge CLK); #1;
    WVALID = 1'b0;
    @(negedge CLK);
    check("len0_back_idle", 64'({burst_active, AWREADY}), 64'b01);
    @(posedge CLK); #1;

    // AWLEN=3, WVALID gapped every other cycle.
    send_aw(4'd1, 32'h2000, 8'd3);
    for (int i = 0; i < 4; i++) begin
      send_w(32'hB000_0000 + 32'(i), 4'h3, (i == 3), (i == 3));
      if (i < 3) begin
        check("len3_still_active", 64'(burst_active), 64'h1);
        @(posedge CLK); #1;
      end
    end
    @(negedge CLK);
    check("len3_idle", 64'(burst_active), 64'h0);
    @(posedge CLK); #1;

    // AWLEN=7, w_fifo_full for 5 cycles after beat 2.
    send_aw(4'd2, 32'h3000, 8'd7);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        w_fifo_full = 1'b1;
        WDATA = 32'hC000_0003; WSTRB = 4'hC; WLAST = 1'b0; WVALID = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge CLK);
          check("full_stall", 64'({WREADY, w_fifo_wr_en, burst_active}), 64'b001);
          @(posedge CLK); #1;
        end
        w_fifo_full = 1'b0;
      end
      send_w(32'hC000_0000 + 32'(i), 4'hC, (i == 7), (i == 7));
    end
    @(negedge CLK);
    check("len7_idle", 64'(burst_active), 64'h0);
    @(posedge CLK); #1;

    // aw_fifo_full holds off the AW.
    aw_fifo_full = 1'b1;
    drive_aw(4'd4, 32'h4000, 8'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check("aw_full_block", 64'({AWREADY, aw_fifo_wr_en}), 64'b00);
      @(posedge CLK); #1;
    end
    aw_fifo_full = 1'b0;
    aw_q.push_back(aw_word(4'd4, 32'h4000, 8'd0));
    @(negedge CLK);
    check("aw_full_release", 64'({AWREADY, aw_fifo_wr_en}), 64'b11);
    @(posedge CLK); #1;
    AWVALID = 1'b0;
    send_w(32'hD000_0000, 4'h1, 1'b1, 1'b1);

    // AWLEN=1 with WLAST wrongly set on beat 0; burst must still end after beat 1.
    send_aw(4'd5, 32'h5000, 8'd1);
    send_w(32'hE000_0000, 4'h8, 1'b1, 1'b0);
    @(negedge CLK);
    check("early_wlast_ignored", 64'(burst_active), 64'h1);
    @(posedge CLK); #1;
    send_w(32'hE000_0001, 4'h8, 1'b1, 1'b1);
    @(negedge CLK);
    check("len1_idle", 64'(burst_active), 64'h0);
    @(posedge CLK); #1;

    // Reset after beat 2 of AWLEN=5.
    send_aw(4'd6, 32'h6000, 8'd5);
    for (int i = 0; i < 3; i++) send_w(32'hF000_0000 + 32'(i), 4'hF, 1'b0, 1'b0);
    ARESTn = 1'b0;
    #1;
    check("mid_reset_outputs", 64'({AWREADY, WREADY, aw_fifo_wr_en, w_fifo_wr_en,
                                    burst_active, wlast_err}), 64'h0);
    @(negedge CLK);
    check("reset_held", 64'({AWREADY, burst_active}), 64'h0);
    @(posedge CLK); #2;
    ARESTn = 1'b1;
    @(negedge CLK);
    check("post_reset_idle", 64'({AWREADY, burst_active}), 64'b10);
    @(posedge CLK); #1;
    send_aw(4'd7, 32'h7000, 8'd0);
    send_w(32'h1234_5678, 4'hF, 1'b1, 1'b1);
    @(negedge CLK);
    check("post_reset_done", 64'(burst_active), 64'h0);

    repeat (2) @(posedge CLK);
    check("aw_queue_drained", 64'(aw_q.size()), 64'h0);
    check("w_queue_drained", 64'(w_q.size()), 64'h0);
    check("aw_push_count", 64'(aw_pushes), 64'd7);
    check("w_push_count", 64'(w_pushes), 64'd20);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
